uart_rx_flow_ctrl: RTL and testbench
====================================

Name: uart_rx_flow_ctrl

Overview:
- Receive-side controller between a serial UART receiver and a byte consumer.
- Drives the receiver's `can_receive_next_word` gate so it only starts a word when buffer space is guaranteed.
- Captures each `ready` pulse into a show-ahead FIFO and presents words to the consumer with a valid/ready handshake.
- Provides enable/drain sequencing, flush, overrun and word-count status.

Parameters:
- WIDTH, 8, data word width; must match the receiver's word width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- COUNT_W, 16, width of the received-word counter.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = accept new words from the receiver.
- flush  in  1  one-cycle pulse; empties the FIFO.
- rx_data  in  WIDTH  word from the receiver; valid only while rx_ready=1.
- rx_ready  in  1  one-cycle pulse from the receiver; the word is complete.
- rx_can_receive  out  1  to the receiver's `can_receive_next_word`.
- out_data  out  WIDTH  head of the FIFO.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  consumer accepts `out_data` when out_valid & out_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky flag; a word was dropped.
- clear_overrun  in  1  pulse; clears `overrun`.
- busy  out  1  FSM is not in IDLE.
- word_count  out  COUNT_W  words stored since reset; wraps modulo 2^COUNT_W.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - FIFO empty; rd/wr pointers = 0; level = 0.
  - out_valid = 0, out_data = 0.
  - rx_can_receive = 0, overrun = 0, busy = 0, word_count = 0.
  - Reset may assert mid-word: all state clears immediately, and a later rx_ready is handled as a normal push.
- FSM states and transitions:
  - IDLE: go to RUN when enable = 1.
  - RUN: go to DRAIN when enable = 0.
  - DRAIN: go to RUN when enable = 1; go to IDLE when enable = 0 and the FIFO is empty.
  - In DRAIN the FIFO still accepts rx_ready pushes, because the receiver may already be mid-word.
- rx_can_receive:
  - Equals (state == RUN) & (level <= DEPTH-2).
  - It is a combinational function of registers only; there is no path from the inputs.
  - This guarantees one free slot for the single word the receiver can have in flight.
- Push:
  - Occurs on an edge with rx_ready = 1 and (level < DEPTH, or a pop on the same edge).
  - Writes rx_data at wr_ptr, increments wr_ptr with wrap modulo DEPTH, and increments word_count.
  - Accepted in every state, including IDLE.
- Drop:
  - Occurs when rx_ready = 1, level == DEPTH and no simultaneous pop.
  - The word is discarded and overrun is set on that edge.
  - If clear_overrun is asserted on the same edge, the set wins.
- Pop:
  - Occurs when out_valid & out_ready; rd_ptr increments with wrap.
- Simultaneous push and pop:
  - level is unchanged.
  - At level 0 (no pop is possible) a push makes out_valid = 1 on the next cycle.
- Latency:
  - A word pushed at edge N into an empty FIFO appears on out_data with out_valid = 1 from edge N.
  - out_data is always mem[rd_ptr], registered show-ahead, with no extra bubble.
- flush:
  - Sets rd_ptr = wr_ptr and level = 0; out_valid drops next cycle.
  - Has priority over a push and a pop on the same edge: a word arriving with flush is discarded.
  - The discarded word is not counted and does not set overrun.
  - The FSM is unaffected.
- Status outputs:
  - busy = (state != IDLE).
  - level is exact; it never exceeds DEPTH.
  - word_count counts stored words only, not dropped or flushed ones.

Test Plan:
- Reset, enable = 1, three rx_ready pulses carrying 0x55, 0xA3, 0x0F, out_ready = 1 → out_data sequence 0x55, 0xA3, 0x0F, each valid the cycle after its push; word_count = 3.
- DEPTH = 4, out_ready = 0, push 0x01..0x02 → level = 2 and rx_can_receive = 1; push 0x03 → level = 3 and rx_can_receive = 0; push 0x04 → level = 4, overrun = 0.
- FIFO full, rx_ready with 0x99 → dropped, overrun = 1, level stays 4; clear_overrun → overrun = 0.
- FIFO full, rx_ready together with a pop → level stays 4; 0x99 becomes the newest entry; overrun = 0.
- enable = 1 → 0 while a word is in flight → state goes to DRAIN and rx_can_receive = 0; the in-flight word 0x7E is still stored; after the consumer pops it, state goes to IDLE and busy = 0.
- Level 2 with flush and rx_ready on the same edge → level = 0, out_valid = 0, word_count unchanged; reset asserted mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_rx_flow_ctrl.sv
// Receive-side flow controller: gates the UART receiver so a word is only started when
// buffer space is guaranteed, buffers words in a show-ahead FIFO and hands them on valid/ready.
module uart_rx_flow_ctrl #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int COUNT_W = 16
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           rx_data,
   input  logic                       rx_ready,
   output logic                       rx_can_receive,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overrun,
   input  logic                       clear_overrun,
   output logic                       busy,
   output logic [COUNT_W-1:0]         word_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ALMOST = LW'(DEPTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr_nxt;
   logic [LW-1:0]      level_nxt;
   logic [WIDTH-1:0]   head_nxt;
   logic               do_push;
   logic               do_pop;
   logic               do_drop;

   // Leaving room for one in-flight word covers the receiver finishing after we deassert.
   assign rx_can_receive = (state == RUN) && (level <= LVL_ALMOST);

   always_comb begin
      do_pop     = out_valid & out_ready & ~flush;
      do_push    = rx_ready & ~flush & ((level != LVL_FULL) | do_pop);
      do_drop    = rx_ready & ~flush & (level == LVL_FULL) & ~do_pop;
      rd_ptr_nxt = do_pop ? rd_ptr + PW'(1) : rd_ptr;
      level_nxt  = level;
      if (do_push && !do_pop) begin
         level_nxt = level + LW'(1);
      end else if (do_pop && !do_push) begin
         level_nxt = level - LW'(1);
      end
      // A word landing exactly at the new head bypasses the memory so it is visible at once.
      if (do_push && (wr_ptr == rd_ptr_nxt)) begin
         head_nxt = rx_data;
      end else begin
         head_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         overrun    <= 1'b0;
         word_count <= '0;
      end else begin
         if (flush) begin
            rd_ptr    <= wr_ptr;
            level     <= '0;
            out_valid <= 1'b0;
         end else begin
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            if (level_nxt != '0) begin
               out_data <= head_nxt;
            end
            if (do_push) begin
               wr_ptr     <= wr_ptr + PW'(1);
               word_count <= word_count + COUNT_W'(1);
            end
         end
         if (do_drop) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   // DRAIN keeps accepting pushes so a word already on the wire is not lost.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (enable) begin
                  state <= RUN;
               end else if (level == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
// Directed bench for uart_rx_flow_ctrl: stored words go into a scoreboard queue and a
// negedge monitor checks every consumer handshake against it; status is checked inline.
module tb_uart_rx_flow_ctrl;

   logic        clock;
   logic        resetn;
   logic        enable;
   logic        flush;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        rx_can_receive;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic        overrun;
   logic        clear_overrun;
   logic        busy;
   logic [15:0] word_count;

   int total;
   int bad;
   logic [7:0] exp_q[$];

   uart_rx_flow_ctrl #(.WIDTH(8), .DEPTH(4), .COUNT_W(16)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .enable         (enable),
      .flush          (flush),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .rx_can_receive (rx_can_receive),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .level          (level),
      .overrun        (overrun),
      .clear_overrun  (clear_overrun),
      .busy           (busy),
      .word_count     (word_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input bit expect_store);
      rx_data  = data;
      rx_ready = 1'b1;
      if (expect_store) exp_q.push_back(data);
      step();
      rx_ready = 1'b0;
      rx_data  = 8'h00;
   endtask

   always @(negedge clock) begin
      if (resetn && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
         end else begin
            checkOutput("scoreboard_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total = 0;
      bad = 0;
      resetn = 1'b0;
      enable = 1'b0;
      flush = 1'b0;
      rx_data = 8'h00;
      rx_ready = 1'b0;
      out_ready = 1'b0;
      clear_overrun = 1'b0;
      step();
      step();
      checkOutput("rst_level", 32'(level), 0);
      checkOutput("rst_valid", 32'(out_valid), 0);
      checkOutput("rst_data", 32'(out_data), 0);
      checkOutput("rst_canrx", 32'(rx_can_receive), 0);
      checkOutput("rst_overrun", 32'(overrun), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_count", 32'(word_count), 0);
      resetn = 1'b1;
      step();

      // Basic streaming with consumer always ready
      enable = 1'b1;
      out_ready = 1'b1;
      step();
      checkOutput("run_busy", 32'(busy), 1);
      checkOutput("run_canrx", 32'(rx_can_receive), 1);
      applyStimulus(8'h55, 1);
      checkOutput("first_valid", 32'(out_valid), 1);
      checkOutput("first_data", 32'(out_data), 32'h55);
      applyStimulus(8'hA3, 1);
      checkOutput("second_data", 32'(out_data), 32'hA3);
      applyStimulus(8'h0F, 1);
      checkOutput("third_data", 32'(out_data), 32'h0F);
      step();
      step();
      checkOutput("stream_level", 32'(level), 0);
      checkOutput("stream_count", 32'(word_count), 3);

      // Fill to full with consumer stalled
      out_ready = 1'b0;
      applyStimulus(8'h01, 1);
      applyStimulus(8'h02, 1);
      checkOutput("lvl2_level", 32'(level), 2);
      checkOutput("lvl2_canrx", 32'(rx_can_receive), 1);
      applyStimulus(8'h03, 1);
      checkOutput("lvl3_level", 32'(level), 3);
      checkOutput("lvl3_canrx", 32'(rx_can_receive), 0);
      applyStimulus(8'h04, 1);
      checkOutput("full_level", 32'(level), 4);
      checkOutput("full_overrun", 32'(overrun), 0);

      // Drop when full, then clear; set beats clear on the same edge
      applyStimulus(8'h99, 0);
      checkOutput("drop_overrun", 32'(overrun), 1);
      checkOutput("drop_level", 32'(level), 4);
      checkOutput("drop_count", 32'(word_count), 7);
      clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      checkOutput("clear_overrun", 32'(overrun), 0);
      clear_overrun = 1'b1;
      applyStimulus(8'h98, 0);
      clear_overrun = 1'b0;
      checkOutput("set_wins", 32'(overrun), 1);
      clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      checkOutput("clear_again", 32'(overrun), 0);

      // Full with simultaneous push and pop
      out_ready = 1'b1;
      applyStimulus(8'h99, 1);
      out_ready = 1'b0;
      checkOutput("pushpop_level", 32'(level), 4);
      checkOutput("pushpop_overrun", 32'(overrun), 0);
      checkOutput("pushpop_count", 32'(word_count), 8);

      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid) break;
         step();
      end
      checkOutput("emptied", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Disable while a word is in flight
      enable = 1'b0;
      applyStimulus(8'h7E, 1);
      checkOutput("drain_busy", 32'(busy), 1);
      checkOutput("drain_canrx", 32'(rx_can_receive), 0);
      checkOutput("drain_level", 32'(level), 1);
      out_ready = 1'b1;
      step();
      checkOutput("drain_popped", 32'(level), 0);
      checkOutput("drain_still_busy", 32'(busy), 1);
      step();
      out_ready = 1'b0;
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("drain_count", 32'(word_count), 9);

      // Flush colliding with a push
      enable = 1'b1;
      step();
      applyStimulus(8'hAA, 1);
      applyStimulus(8'hBB, 1);
      checkOutput("preflush_level", 32'(level), 2);
      flush = 1'b1;
      applyStimulus(8'hCC, 0);
      flush = 1'b0;
      exp_q.delete();
      checkOutput("flush_level", 32'(level), 0);
      checkOutput("flush_valid", 32'(out_valid), 0);
      checkOutput("flush_count", 32'(word_count), 11);
      checkOutput("flush_overrun", 32'(overrun), 0);
      applyStimulus(8'hDD, 1);
      checkOutput("postflush_data", 32'(out_data), 32'hDD);
      checkOutput("postflush_level", 32'(level), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Asynchronous reset in mid-stream
      applyStimulus(8'hEE, 1);
      #2;
      resetn = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("arst_level", 32'(level), 0);
      checkOutput("arst_valid", 32'(out_valid), 0);
      checkOutput("arst_data", 32'(out_data), 0);
      checkOutput("arst_canrx", 32'(rx_can_receive), 0);
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_count", 32'(word_count), 0);
      step();
      resetn = 1'b1;
      step();
      out_ready = 1'b1;
      applyStimulus(8'h42, 1);
      step();
      out_ready = 1'b0;
      checkOutput("post_rst_count", 32'(word_count), 1);
      checkOutput("post_rst_level", 32'(level), 0);

      step();
      checkOutput("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
